// File: rtl/rv32m_muldiv_unit_if.sv
// Issue/result bundle between the execute stage and the RV32M multiply/divide unit.
// The core drives start/MDOp/A/B and stalls on busy; the unit returns Result with a done pulse.
interface rv32m_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      MDOp;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] Result;

  modport master (
    output start, MDOp, A, B,
    input  busy, done, Result
  );

  modport slave (
    input  start, MDOp, A, B,
    output busy, done, Result
  );
endinterface

// File: rtl/rv32m_muldiv_unit.sv
// Iterative RV32M multiply (shift-add) / divide (restoring) unit, 32 iterations per operation.
// Define MULDIV_FAST_MUL_EN to resolve multiplies in a single cycle with a combinational product.
module rv32m_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rv32m_muldiv_unit_if.slave   md
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  // Operand preparation for the request presented in IDLE
  always_comb begin
    a_signed    = (md.MDOp == 3'b001) || (md.MDOp == 3'b010) ||
                  (md.MDOp == 3'b100) || (md.MDOp == 3'b110);
    b_signed    = (md.MDOp == 3'b001) || (md.MDOp == 3'b100) || (md.MDOp == 3'b110);
    a_neg       = a_signed & md.A[XLEN-1];
    b_neg       = b_signed & md.B[XLEN-1];
    a_mag       = a_neg ? (~md.A + 1'b1) : md.A;
    b_mag       = b_neg ? (~md.B + 1'b1) : md.B;
    div_zero    = md.MDOp[2] && (md.B == '0);
    div_ovf     = md.MDOp[2] && !md.MDOp[0] &&
                  (md.A == {1'b1, {(XLEN-1){1'b0}}}) && (md.B == {XLEN{1'b1}});
    special_res = '0;
    if (div_zero) begin
      special_res = md.MDOp[1] ? md.A : {XLEN{1'b1}};
    end else begin
      special_res = md.MDOp[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_signed;
  logic [XLEN-1:0]   fast_res;

  always_comb begin
    fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    fast_signed = (a_neg ^ b_neg) ? (~fast_prod + 1'b1) : fast_prod;
    fast_res    = (md.MDOp[1:0] == 2'b00) ? fast_signed[XLEN-1:0] : fast_signed[2*XLEN-1:XLEN];
  end
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_part, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step_next, prod_fix;
  logic [XLEN-1:0]   quot, rem, fin_res;

  // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_part  = acc_q[2*XLEN-1:XLEN-1];
    div_ge    = div_part >= {1'b0, opnd_q};
    div_diff  = div_part - {1'b0, opnd_q};
    step_next = '0;
    if (op_q[2]) begin
      step_next = {(div_ge ? div_diff[XLEN-1:0] : div_part[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end else begin
      step_next = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fix = qneg_q ? (~step_next + 1'b1) : step_next;
    quot     = step_next[XLEN-1:0];
    rem      = step_next[2*XLEN-1:XLEN];
    fin_res  = '0;
    case (op_q)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = qneg_q ? (~quot + 1'b1) : quot;
      default:                fin_res = rneg_q ? (~rem + 1'b1) : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (md.start) begin
          op_d   = md.MDOp;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          cnt_d  = '0;
          acc_d  = {{XLEN{1'b0}}, (md.MDOp[2] ? a_mag : b_mag)};
          opnd_d = md.MDOp[2] ? b_mag : a_mag;
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!md.MDOp[2]) begin
            result_d = fast_res;
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign md.busy   = (state_q != S_IDLE);
  assign md.done   = (state_q == S_DONE);
  assign md.Result = result_q;

endmodule
